// File: rtl/fir_pcpi_sequencer.sv
// PCPI front end for the FIR accelerator: decodes custom-0 ops and sequences coefficient, shift and
// compute strobes. Define FIR_PCPI_SEQ_PERF_EN to build the WAIT_ACC cycle counter read by PERF.
module fir_pcpi_sequencer #(
   parameter int unsigned K                 = 128,
   parameter int unsigned N                 = 7,
   parameter int unsigned WIDTH_COEFFICIENT = 32,
   parameter int unsigned NUM_ADD_CLK       = 4,
   parameter logic [6:0]  CUSTOM_OPCODE     = 7'b0001011
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         pcpi_valid,
   input  logic [31:0]                  pcpi_insn,
   input  logic [31:0]                  pcpi_rs1,
   input  logic [31:0]                  pcpi_rs2,
   output logic                         pcpi_wr,
   output logic [31:0]                  pcpi_rd,
   output logic                         pcpi_wait,
   output logic                         pcpi_ready,
   output logic                         coef_we,
   output logic [$clog2(K*N)-1:0]       coef_addr,
   output logic [WIDTH_COEFFICIENT-1:0] coef_wdata,
   output logic                         shift_en,
   output logic [N-1:0]                 shift_data,
   output logic                         acc_start,
   input  logic [31:0]                  acc_result,
   output logic [5:0]                   pcpi_insn_decoded
);

   localparam int unsigned AW = $clog2(K*N);
   localparam int unsigned FW = $clog2(K+1);
   localparam int unsigned LW = $clog2(NUM_ADD_CLK+1);

   localparam logic [2:0] OpLoadc   = 3'd0;
   localparam logic [2:0] OpPush    = 3'd1;
   localparam logic [2:0] OpCompute = 3'd2;
   localparam logic [2:0] OpStatus  = 3'd3;
   localparam logic [2:0] OpClrfill = 3'd4;
   localparam logic [2:0] OpPerf    = 3'd5;

   typedef enum logic [2:0] {StIdle, StExec, StWaitAcc, StResp, StHold} state_e;

   state_e                       state_q, state_d;
   logic [2:0]                   op_q;
   logic [31:0]                  rs1_q;
   logic [WIDTH_COEFFICIENT-1:0] rs2_q;
   logic [5:0]                   decoded_q, decoded_d;
   logic [FW-1:0]                fill_q;
   logic                         err_q;
   logic [31:0]                  result_q;
   logic [LW-1:0]                lat_q;
   logic [31:0]                  perf_val;
   logic                         match, accept, coef_ok, fill_full, wr_op;
   logic                         unused_ok;

   assign match     = pcpi_valid && (pcpi_insn[6:0] == CUSTOM_OPCODE) && (pcpi_insn[31:25] == 7'd0);
   assign accept    = (state_q == StIdle) && match;
   assign coef_ok   = rs1_q < 32'(K*N);
   assign fill_full = fill_q == FW'(K);
   assign wr_op     = (op_q == OpCompute) || (op_q == OpStatus) || (op_q == OpPerf);
   assign unused_ok = ^{pcpi_insn[24:15], pcpi_insn[11:7], pcpi_rs2};

   assign pcpi_insn_decoded = decoded_q;

   always_comb begin
      decoded_d = '0;
      if (pcpi_insn[14:12] < 3'd6) decoded_d = 6'b1 << pcpi_insn[14:12];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= StIdle;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (match) state_d = StExec;
         StExec:    state_d = (op_q == OpCompute && fill_full) ? StWaitAcc : StResp;
         StWaitAcc: if (lat_q == LW'(1)) state_d = StResp;
         StResp:    state_d = StHold;
         StHold:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      pcpi_wr    = 1'b0;
      pcpi_rd    = '0;
      pcpi_wait  = 1'b0;
      pcpi_ready = 1'b0;
      coef_we    = 1'b0;
      coef_addr  = '0;
      coef_wdata = '0;
      shift_en   = 1'b0;
      shift_data = '0;
      acc_start  = 1'b0;
      unique case (state_q)
         StExec: begin
            pcpi_wait = 1'b1;
            if (op_q == OpLoadc && coef_ok) begin
               coef_we    = 1'b1;
               coef_addr  = rs1_q[AW-1:0];
               coef_wdata = rs2_q;
            end
            if (op_q == OpPush) begin
               shift_en   = 1'b1;
               shift_data = rs1_q[N-1:0];
            end
            if (op_q == OpCompute) acc_start = fill_full;
         end
         StWaitAcc: pcpi_wait = 1'b1;
         StResp: begin
            pcpi_ready = 1'b1;
            pcpi_wr    = wr_op;
            pcpi_rd    = wr_op ? result_q : 32'd0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         op_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         decoded_q <= '0;
         fill_q    <= '0;
         err_q     <= 1'b0;
         result_q  <= '0;
         lat_q     <= '0;
      end else if (accept) begin
         op_q      <= pcpi_insn[14:12];
         rs1_q     <= pcpi_rs1;
         rs2_q     <= pcpi_rs2[WIDTH_COEFFICIENT-1:0];
         decoded_q <= decoded_d;
      end else if (state_q == StExec) begin
         result_q <= '0;
         case (op_q)
            OpLoadc:   if (!coef_ok) err_q <= 1'b1;
            OpPush:    if (!fill_full) fill_q <= fill_q + FW'(1);
            OpCompute: begin
               if (fill_full) lat_q <= LW'(NUM_ADD_CLK);
               else           err_q <= 1'b1;
            end
            // busy reads as 0: the CPU is stalled whenever the block is busy
            OpStatus:  result_q <= {16'(fill_q), 13'd0, err_q, fill_full, 1'b0};
            OpClrfill: begin
               fill_q <= '0;
               err_q  <= 1'b0;
            end
            OpPerf:    result_q <= perf_val;
            default:   err_q <= 1'b1;
         endcase
      end else if (state_q == StWaitAcc) begin
         lat_q <= lat_q - LW'(1);
         if (lat_q == LW'(1)) result_q <= acc_result;
      end
   end

`ifdef FIR_PCPI_SEQ_PERF_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                                      perf_q <= '0;
      else if (state_q == StWaitAcc)                    perf_q <= perf_q + 32'd1;
      else if (state_q == StExec && op_q == OpClrfill)  perf_q <= '0;
   end

   assign perf_val = perf_q;
`else
   assign perf_val = 32'd0;
`endif

endmodule

// File: doc/fir_pcpi_sequencer.md
Name: fir_pcpi_sequencer

Overview:
- Sequences the FIR accelerator datapath from the picorv32 PCPI port.
- Decodes custom-0 instructions, drives coefficient writes, sample shifts and compute starts, and waits out the fixed adder-tree latency.
- Returns results and status to the CPU.
- Sits between the picorv32 core and the FIR datapath (coefficient memory, shift register, adder tree) in the top level.

Parameters:
K, 128, filter taps per channel
N, 7, control-bit channels per sample
WIDTH_COEFFICIENT, 32, coefficient width in bits
NUM_ADD_CLK, 4, adder-tree pipeline latency in cycles (>=1)
CUSTOM_OPCODE, 7'b0001011, PCPI opcode claimed by this block

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
pcpi_valid  in  1  PCPI request valid, held by CPU until pcpi_ready
pcpi_insn  in  32  instruction word
pcpi_rs1  in  32  operand 1
pcpi_rs2  in  32  operand 2
pcpi_wr  out  1  write pcpi_rd to rd, qualified by pcpi_ready
pcpi_rd  out  32  result to CPU
pcpi_wait  out  1  instruction claimed, stall CPU
pcpi_ready  out  1  one-cycle completion pulse
coef_we  out  1  coefficient write strobe
coef_addr  out  $clog2(K*N)  coefficient index
coef_wdata  out  WIDTH_COEFFICIENT  coefficient value
shift_en  out  1  shift one sample into the datapath
shift_data  out  N  sample control bits
acc_start  out  1  one-cycle compute start pulse
acc_result  in  32  adder-tree output, valid NUM_ADD_CLK cycles after acc_start
pcpi_insn_decoded  out  6  one-hot decoded op, for debug

Behaviour:
- Reset: clk and resetn are the only clock and reset. Reset is asynchronous on resetn low. All outputs are 0; state is IDLE; fill_cnt, err and the result register are 0. Datapath coefficient contents are not cleared.
- Match: pcpi_valid, insn[6:0]==CUSTOM_OPCODE and insn[31:25]==0. Non-matching instructions are ignored: no pcpi_wait, no pcpi_ready.
- Ops by funct3 = insn[14:12], with the matching pcpi_insn_decoded bit:
  - 0 LOADC, bit0.
  - 1 PUSH, bit1.
  - 2 COMPUTE, bit2.
  - 3 STATUS, bit3.
  - 4 CLRFILL, bit4.
  - 5 PERF, bit5.
  - 6 and 7 are illegal: complete with pcpi_wr=0 and set err.
- pcpi_insn_decoded is registered on accept and held until the next accept.
- States:
  - IDLE: on match, latch insn, rs1 and rs2, and go to EXEC. pcpi_wait is high from the cycle after accept until pcpi_ready.
  - EXEC:
    - LOADC: if rs1 < K*N, pulse coef_we with coef_addr=rs1 and coef_wdata=rs2[WIDTH_COEFFICIENT-1:0]; otherwise set err and do not write.
    - PUSH: pulse shift_en with shift_data=rs1[N-1:0]; fill_cnt++ saturating at K.
    - COMPUTE: if fill_cnt==K, pulse acc_start, load lat_cnt=NUM_ADD_CLK and go to WAIT_ACC; otherwise set err and return 0.
    - CLRFILL: fill_cnt=0, err=0.
    - All other ops go to RESP.
  - WAIT_ACC: lat_cnt decrements each cycle. At 0, capture acc_result and go to RESP.
  - RESP: pcpi_ready=1 for exactly one cycle.
    - pcpi_wr=1 for COMPUTE, STATUS and PERF; pcpi_wr=0 for the rest.
    - pcpi_rd carries the result and is 0 when pcpi_wr=0.
    - Then go to HOLD.
  - HOLD: one cycle ignoring pcpi_valid, because the CPU drops valid the cycle after ready. Then IDLE.
- STATUS word: [0] busy (always 0 when read), [1] fill_cnt==K, [2] err, [31:16] fill_cnt.
- Latency (accept at cycle 0):
  - LOADC, PUSH, CLRFILL, STATUS: ready at cycle 2.
  - COMPUTE: acc_start at 1, capture at 1+NUM_ADD_CLK, ready at 2+NUM_ADD_CLK.
- Only one op is in flight at a time. New pcpi_valid is ignored outside IDLE.
- Reset mid-operation (e.g. in WAIT_ACC) aborts the op immediately: no pcpi_ready, and no late acc_result capture.

Optional Feature:
FIR_PCPI_SEQ_PERF_EN:
- Defined: a 32-bit cycle counter increments every cycle that state is WAIT_ACC, wrapping at 2^32-1 to 0. It is cleared by reset and by CLRFILL. PERF (funct3=5) returns it.
- Undefined: no counter is built, and PERF returns 0 with pcpi_wr=1.

Test Plan:
- LOADC rs1=5, rs2=0xDEADBEEF -> coef_we one pulse, coef_addr=5, coef_wdata=0xDEADBEEF; ready at cycle 2; pcpi_wr=0.
- LOADC rs1=K*N (896) -> no coef_we; STATUS then returns bit2=1.
- COMPUTE after only 3 PUSHes -> no acc_start; pcpi_rd=0, pcpi_wr=1; err=1.
- 128 PUSHes, then COMPUTE with acc_result forced to 0x1234 -> acc_start at cycle 1, ready at cycle 6 (NUM_ADD_CLK=4), pcpi_rd=0x1234; STATUS returns 0x0080_0002.
- pcpi_valid held one extra cycle after ready -> no second execution; shift_en pulse count unchanged.
- resetn low during WAIT_ACC -> outputs 0 asynchronously, no pcpi_ready; STATUS after reset returns 0; with FIR_PCPI_SEQ_PERF_EN, PERF returns 4 after one COMPUTE from reset.
